rcom_cmd_sequencer: RTL
=======================

// Module: rcom_cmd_sequencer
// PURPOSE
//  Upstream driver for RemoteComm. Holds a small table of 16-bit Knight commands
//  (e.g. 0x0000 calibrate, 0x23F1 move W1) and issues them in order.
//  Per command: pulses snd_cmd, waits for cmd_snt, then waits for resp_rdy and checks resp.
//  Stops at end of table or on first failure. Lets full-tour benches and FPGA demo
//  replace hand-written per-command send/wait sequences.
// PARAMETERS
//  DEPTH       16          command slots; power of 2; ADDR_W = $clog2(DEPTH)
//  TMO_CYCLES  10_000_000  max clk cycles allowed in each wait state
//  GAP_CYCLES  64          idle clk cycles between resp_rdy and next snd_cmd (>=1)
//  RESP_OK     8'hA5       expected response code
// PORTS
//  clk       in   1         system clock
//  rst_n     in   1         asynchronous active-low reset
//  wr_en     in   1         table write strobe (ignored while busy)
//  wr_addr   in   ADDR_W    table slot to write
//  wr_data   in   16        command word to write
//  num_cmds  in   ADDR_W+1  commands to run (0..DEPTH); sampled on start
//  start     in   1         begin sequence (ignored while busy)
//  cmd       out  16        command to RemoteComm
//  snd_cmd   out  1         one-cycle send pulse to RemoteComm
//  cmd_snt   in   1         RemoteComm: both bytes transmitted
//  resp_rdy  in   1         RemoteComm: response byte valid
//  resp      in   8         RemoteComm: response byte
//  busy      out  1         sequence in progress
//  done      out  1         sticky: sequence completed with no error
//  err       out  1         sticky: sequence aborted
//  err_code  out  2         00 none, 01 cmd_snt timeout, 10 resp timeout, 11 bad resp
//  cmd_idx   out  ADDR_W+1  index of current/failing command
//  pass_cnt  out  ADDR_W+1  commands acknowledged with RESP_OK
// BEHAVIOUR
//  Reset: state IDLE; cmd=0, snd_cmd=0, busy=0, done=0, err=0, err_code=0,
//   cmd_idx=0, pass_cnt=0, timer=0. The table is not reset.
//  States:
//   IDLE: start & num_cmds==0 -> DONE. start & num_cmds>0 -> LOAD.
//    On start: latch n, clear done/err/err_code/cmd_idx/pass_cnt.
//   LOAD: cmd <= table[cmd_idx] -> SEND. cmd is held stable until the next LOAD.
//   SEND: snd_cmd=1 for exactly this cycle; timer cleared -> WAIT_SNT.
//   WAIT_SNT: cmd_snt -> WAIT_RESP, timer cleared.
//    timer==TMO_CYCLES-1 -> ERR, err_code=01. resp_rdy is ignored here.
//   WAIT_RESP: resp_rdy & resp==RESP_OK -> pass_cnt++, cmd_idx++.
//    If cmd_idx+1==n -> DONE, else -> GAP, timer cleared.
//    resp_rdy & resp!=RESP_OK -> ERR, err_code=11.
//    Else timer==TMO_CYCLES-1 -> ERR, err_code=10.
//    If resp_rdy and the timeout fall in the same cycle, resp_rdy wins.
//   GAP: timer==GAP_CYCLES-1 -> LOAD.
//   DONE: done=1 -> IDLE. ERR: err=1 -> IDLE. cmd_idx holds the failing index.
//  busy=1 in every state except IDLE. It falls in the same cycle that done/err rise.
//  Latency: start to snd_cmd = 2 clk (IDLE->LOAD->SEND).
//  Timer width: $clog2(TMO_CYCLES) bits, saturating, cleared on every state entry.
//  wr_en while busy is dropped (table write-protected during a run).
//  wr_en and start in the same IDLE cycle: the write lands and the run uses the new value.
//  Async reset mid-sequence: immediate return to reset values, no snd_cmd glitch.
//   RemoteComm is reset by the same rst_n.
// STRUCTURE
//  Shared package rcom_seq_pkg: seq_state_t enum, err_code_t enum (ERR_NONE,
//   ERR_SNT_TMO, ERR_RESP_TMO, ERR_BAD_RESP), RESP_OK constant, CMD_CAL=16'h0000.
//  Sub-module seq_cmd_mem: DEPTH x 16 register file with synchronous write and
//   combinational read. Controller FSM, timer and counters live in the top.
// TESTING (bench: sequencer -> RemoteComm -> KnightsTour + KnightPhysics)
//  1. Load {0x0000}, n=1, start.
//     -> snd_cmd pulse 2 clk after start; cal_done, resp=A5; done=1, pass_cnt=1.
//  2. Load {0x0000, 0x23F1}, n=2.
//     -> 0x23F1 issued GAP_CYCLES after first resp_rdy; frwrd returns to 0.
//     -> done=1, pass_cnt=2, err=0.
//  3. n=0, start -> done=1 one cycle after IDLE exit; snd_cmd never asserted.
//  4. Stub RemoteComm returns resp=5A -> err=1, err_code=11, cmd_idx=0, pass_cnt=0.
//  5. Stub holds cmd_snt low, TMO_CYCLES=1000 -> err_code=01 after exactly 1000 cycles.
//     Repeat with resp_rdy withheld -> err_code=10.
//  6. Assert rst_n low in WAIT_RESP -> all outputs 0 immediately.
//     Also: wr_en while busy leaves table unchanged; start while busy is ignored.

Source files
------------

// File: rtl/rcom_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rcom_seq_pkg
//  Brief    : Shared types and constants for the RemoteComm command sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package rcom_seq_pkg;

  // Controller states; IDLE is the only non-busy state.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_SNT  = 3'd3,
    ST_WAIT_RESP = 3'd4,
    ST_GAP       = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERR       = 3'd7
  } seq_state_t;

  // Abort reasons reported on err_code.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_SNT_TMO  = 2'b01,
    ERR_RESP_TMO = 2'b10,
    ERR_BAD_RESP = 2'b11
  } err_code_t;

  // Response byte RemoteComm returns for an accepted command.
  localparam logic [7:0]  RESP_OK = 8'hA5;
  // Knight calibrate command; also the idle value of the command bus.
  localparam logic [15:0] CMD_CAL = 16'h0000;

endpackage
`default_nettype wire

// File: rtl/seq_cmd_mem.sv
`default_nettype none
// ============================================================================
//  Module   : seq_cmd_mem
//  Brief    : DEPTH x 16 command table, synchronous write, combinational read.
//             Contents are deliberately not reset.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_cmd_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [15:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [15:0]       o_rdata
);

  logic [15:0] r_mem [DEPTH];

  // Table write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/rcom_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rcom_cmd_sequencer
//  Brief    : Issues a table of Knight commands to RemoteComm in order, waiting
//             for cmd_snt and a response per command; stops at end of table or
//             on the first timeout / bad response.
//  Revision : 1.0 - initial release
// ============================================================================
module rcom_cmd_sequencer
  import rcom_seq_pkg::*;
#(
  parameter int         DEPTH      = 16,
  parameter int         TMO_CYCLES = 10_000_000,
  parameter int         GAP_CYCLES = 64,
  parameter logic [7:0] RESP_OK    = rcom_seq_pkg::RESP_OK,
  localparam int        ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic [ADDR_W:0]   num_cmds,
  input  logic              start,
  output logic [15:0]       cmd,
  output logic              snd_cmd,
  input  logic              cmd_snt,
  input  logic              resp_rdy,
  input  logic [7:0]        resp,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   cmd_idx,
  output logic [ADDR_W:0]   pass_cnt
);

  localparam int                IDX_W     = ADDR_W + 1;
  localparam int                TMR_W     = $clog2(TMO_CYCLES);
  localparam logic [TMR_W-1:0]  C_TMR_MAX = '1;
  localparam logic [TMR_W-1:0]  C_TMO_END = TMR_W'(TMO_CYCLES - 1);
  localparam logic [TMR_W-1:0]  C_GAP_END = TMR_W'(GAP_CYCLES - 1);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [TMR_W-1:0]  r_timer;
  logic [IDX_W-1:0]  r_n;
  logic [IDX_W-1:0]  r_cmd_idx;
  logic [IDX_W-1:0]  r_pass_cnt;
  logic [15:0]       r_cmd;
  logic              r_snd_cmd;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  err_code_t         r_err_code;

  logic              w_start_run;
  logic              w_load;
  logic              w_pass;
  logic              w_err_set;
  err_code_t         w_err_code_nxt;
  logic              w_tmo;
  logic              w_tbl_we;
  logic [15:0]       w_tbl_rdata;

  // The table is write-protected for the whole run, not just while busy is seen.
  assign w_tbl_we = wr_en & (r_state == ST_IDLE);
  assign w_tmo    = (r_timer == C_TMO_END);

  seq_cmd_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_cmd_mem (
    .clk     (clk),
    .i_we    (w_tbl_we),
    .i_waddr (wr_addr),
    .i_wdata (wr_data),
    .i_raddr (r_cmd_idx[ADDR_W-1:0]),
    .o_rdata (w_tbl_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    w_state_nxt    = r_state;
    w_start_run    = 1'b0;
    w_load         = 1'b0;
    w_pass         = 1'b0;
    w_err_set      = 1'b0;
    w_err_code_nxt = ERR_NONE;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_run = 1'b1;
          w_state_nxt = (num_cmds == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        w_state_nxt = ST_WAIT_SNT;
      end
      ST_WAIT_SNT: begin
        if (cmd_snt) begin
          w_state_nxt = ST_WAIT_RESP;
        end else if (w_tmo) begin
          w_state_nxt    = ST_ERR;
          w_err_set      = 1'b1;
          w_err_code_nxt = ERR_SNT_TMO;
        end
      end
      ST_WAIT_RESP: begin
        // A response arriving on the timeout cycle still counts.
        if (resp_rdy) begin
          if (resp == RESP_OK) begin
            w_pass      = 1'b1;
            w_state_nxt = ((r_cmd_idx + IDX_W'(1)) == r_n) ? ST_DONE : ST_GAP;
          end else begin
            w_state_nxt    = ST_ERR;
            w_err_set      = 1'b1;
            w_err_code_nxt = ERR_BAD_RESP;
          end
        end else if (w_tmo) begin
          w_state_nxt    = ST_ERR;
          w_err_set      = 1'b1;
          w_err_code_nxt = ERR_RESP_TMO;
        end
      end
      ST_GAP: begin
        if (r_timer == C_GAP_END) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Wait timer: restarts on every state entry and saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (w_state_nxt != r_state) begin
      r_timer <= '0;
    end else if (r_timer != C_TMR_MAX) begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  // Run bookkeeping: command count, indices, status flags and command bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n        <= '0;
      r_cmd_idx  <= '0;
      r_pass_cnt <= '0;
      r_cmd      <= CMD_CAL;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      if (w_start_run) begin
        r_n        <= num_cmds;
        r_cmd_idx  <= '0;
        r_pass_cnt <= '0;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
      end
      if (w_load) begin
        r_cmd <= w_tbl_rdata;
      end
      if (w_pass) begin
        r_cmd_idx  <= r_cmd_idx + IDX_W'(1);
        r_pass_cnt <= r_pass_cnt + IDX_W'(1);
      end
      if (w_err_set) begin
        r_err_code <= w_err_code_nxt;
      end
      if (r_state == ST_DONE) begin
        r_done <= 1'b1;
      end
      if (r_state == ST_ERR) begin
        r_err <= 1'b1;
      end
    end
  end

  // Registered strobes so snd_cmd and busy come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snd_cmd <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_snd_cmd <= (w_state_nxt == ST_SEND);
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  assign cmd      = r_cmd;
  assign snd_cmd  = r_snd_cmd;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign err_code = r_err_code;
  assign cmd_idx  = r_cmd_idx;
  assign pass_cnt = r_pass_cnt;

endmodule
`default_nettype wire
